// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types, constants and address-split helpers for the
//               direct-mapped instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Bits [1:0] are the byte offset within a word and never take part.
    function automatic int tag_bits(input int addr_width, input int sets,
                                    input int words_per_line);
        return addr_width - 2 - index_bits(sets) - offset_bits(words_per_line);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_fsm.sv
// ============================================================================
// Module      : icache_refill_fsm
// Description : Line-refill controller: state, beat counter, refill request
//               and deferred-flush tracking; drives the cache array writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  miss,
    input  logic                                  flush,
    input  logic                                  mem_rvalid,
    input  logic [ADDR_WIDTH-1:0]                 line_base,
    output state_t                                state,
    output logic                                  mem_req,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic                                  beat_we,
    output logic [offset_bits(WORDS_PER_LINE)-1:0] beat_word,
    output logic                                  line_we,
    output logic                                  line_valid,
    output logic                                  clear_all
);

    localparam int                 c_off_w = offset_bits(WORDS_PER_LINE);
    localparam logic [c_off_w-1:0] c_last  = c_off_w'(WORDS_PER_LINE - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_off_w-1:0]    r_count;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_flush_pending;
    logic                  w_beat;
    logic                  w_last_beat;

    assign w_beat      = (r_state == REFILL) && mem_rvalid;
    assign w_last_beat = w_beat && (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (miss)        w_next_state = REFILL;
            REFILL:  if (w_last_beat) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count         <= '0;
            r_mem_addr      <= '0;
            r_flush_pending <= 1'b0;
        end else if (r_state == IDLE) begin
            if (miss) begin
                r_count         <= '0;
                r_mem_addr      <= line_base;
                r_flush_pending <= 1'b0;
            end
        end else begin
            if (w_beat) begin
                r_count <= r_count + 1'b1;
            end
            if (w_last_beat) begin
                r_flush_pending <= 1'b0;
            end else if (flush) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    // A flush seen at any point of a refill, including its last beat, keeps
    // the new line invalid and wipes the whole array on completion.
    always_comb begin
        mem_req    = (r_state == REFILL);
        beat_we    = w_beat;
        beat_word  = r_count;
        line_we    = w_last_beat;
        line_valid = !(r_flush_pending || flush);
        clear_all  = ((r_state == IDLE) && flush)
                  || (w_last_beat && (r_flush_pending || flush));
    end

    assign state    = r_state;
    assign mem_addr = r_mem_addr;

endmodule

`default_nettype wire

// File: rtl/instr_cache.sv
// ============================================================================
// Module      : instr_cache
// Description : Direct-mapped read-only instruction cache with same-cycle
//               hits and stalling line refill from backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_cache
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_req,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  instr_valid,
    output logic                  stall_o,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int c_off_w   = offset_bits(WORDS_PER_LINE);
    localparam int c_idx_w   = index_bits(SETS);
    localparam int c_tag_w   = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
    localparam int c_idx_lsb = 2 + c_off_w;
    localparam int c_tag_lsb = c_idx_lsb + c_idx_w;

    logic [DATA_WIDTH-1:0] r_data [SETS][WORDS_PER_LINE];
    logic [c_tag_w-1:0]    r_tag  [SETS];
    logic [SETS-1:0]       r_valid;

    logic [c_off_w-1:0]    w_off;
    logic [c_idx_w-1:0]    w_idx;
    logic [c_tag_w-1:0]    w_tag;
    logic [ADDR_WIDTH-1:0] w_line_base;
    logic [c_idx_w-1:0]    w_fill_idx;
    logic [c_tag_w-1:0]    w_fill_tag;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_unused_bits;

    state_t                w_state;
    logic                  w_beat_we;
    logic [c_off_w-1:0]    w_beat_word;
    logic                  w_line_we;
    logic                  w_line_valid;
    logic                  w_clear_all;

    assign w_off       = fetch_addr[2 +: c_off_w];
    assign w_idx       = fetch_addr[c_idx_lsb +: c_idx_w];
    assign w_tag       = fetch_addr[c_tag_lsb +: c_tag_w];
    assign w_line_base = {fetch_addr[ADDR_WIDTH-1:c_idx_lsb], {c_idx_lsb{1'b0}}};
    assign w_fill_idx  = mem_addr[c_idx_lsb +: c_idx_w];
    assign w_fill_tag  = mem_addr[c_tag_lsb +: c_tag_w];
    assign w_unused_bits = &{1'b0, fetch_addr[1:0], mem_addr[c_idx_lsb-1:0]};

    // A flush in the same cycle as a fetch must miss, so it masks the hit.
    assign w_hit  = fetch_req && !rst && !flush && (w_state == IDLE)
                 && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = fetch_req && !w_hit;

    assign instr_valid = w_hit;
    assign instr_o     = w_hit ? r_data[w_idx][w_off] : DATA_WIDTH'(c_nop);
    assign stall_o     = !rst && ((w_state == REFILL) || w_miss);

    icache_refill_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clk        (clk),
        .rst        (rst),
        .miss       (w_miss),
        .flush      (flush),
        .mem_rvalid (mem_rvalid),
        .line_base  (w_line_base),
        .state      (w_state),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .beat_we    (w_beat_we),
        .beat_word  (w_beat_word),
        .line_we    (w_line_we),
        .line_valid (w_line_valid),
        .clear_all  (w_clear_all)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_clear_all) begin
            r_valid <= '0;
        end else if (w_line_we && w_line_valid) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat_we) begin
            r_data[w_fill_idx][w_beat_word] <= mem_rdata;
        end
        if (w_line_we) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_cache.sv
// ============================================================================
// Module      : tb_instr_cache
// Description : Self-checking bench for instr_cache: vector table, directed
//               corner sequences and random fetches against a line model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_cache;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_addr = '0;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic        stall_o;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which line base address each set currently holds.
    logic [31:0] line_tab [int];

    typedef struct {
        logic [31:0] addr;
        int          gap;
        bit          exp_hit;
    } vec_t;

    vec_t tbl [10];

    instr_cache dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .instr_o     (instr_o),
        .instr_valid (instr_valid),
        .stall_o     (stall_o),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'h10) return 32'hA0 + (w >> 2);
        return (w * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // fl: -1 none, 0 flush together with the request, k+1 flush with beat k.
    task automatic fetch(input logic [31:0] a, input int gap, input int fl, input bit exp_hit);
        logic [31:0] base;
        int          idx;
        base = {a[31:4], 4'h0};
        idx  = int'(a[9:4]);
        if (fl == 0) line_tab.delete();
        @(negedge clk);
        fetch_addr = a; fetch_req = 1'b1; mem_rvalid = 1'b0; flush = (fl == 0);
        #1;
        chk1("instr_valid", instr_valid, exp_hit);
        if (exp_hit) begin
            chk("hit_data", instr_o, mem_val(a));
            chk1("hit_stall", stall_o, 1'b0);
            chk1("hit_mem_req", mem_req, 1'b0);
        end else begin
            chk1("miss_stall", stall_o, 1'b1);
            chk("miss_nop", instr_o, c_nop);
            @(negedge clk); flush = 1'b0; #1;
            chk1("refill_req", mem_req, 1'b1);
            chk("refill_addr", mem_addr, base);
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk); mem_rvalid = 1'b0; mem_rdata = $urandom; flush = 1'b0; #1;
                    chk1("gap_stall", stall_o, 1'b1);
                    chk("gap_addr", mem_addr, base);
                end
                @(negedge clk);
                mem_rvalid = 1'b1; mem_rdata = mem_val(base + 32'(4 * k)); flush = (fl == k + 1);
                #1;
                chk1("beat_stall", stall_o, 1'b1);
                chk1("beat_valid", instr_valid, 1'b0);
            end
            @(negedge clk); mem_rvalid = 1'b0; flush = 1'b0; #1;
            chk1("done_req", mem_req, 1'b0);
            if (fl > 0) begin
                chk1("flushed_valid", instr_valid, 1'b0);
                chk1("flushed_stall", stall_o, 1'b1);
                fetch_req = 1'b0;
                line_tab.delete();
            end else begin
                chk1("refetch_valid", instr_valid, 1'b1);
                chk("refetch_data", instr_o, mem_val(a));
                chk1("refetch_stall", stall_o, 1'b0);
                line_tab[idx] = base;
            end
        end
    endtask

    task automatic model_fetch(input logic [31:0] a, input int gap, input int fl);
        bit eh;
        int idx;
        idx = int'(a[9:4]);
        eh  = (fl != 0) && line_tab.exists(idx) && (line_tab[idx] == {a[31:4], 4'h0});
        fetch(a, gap, fl, eh);
    endtask

    task automatic do_flush();
        @(negedge clk); fetch_req = 1'b0; flush = 1'b1; #1;
        chk1("flush_stall", stall_o, 1'b0);
        @(negedge clk); flush = 1'b0;
        line_tab.delete();
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 3, 1'b0};
        tbl[1] = '{32'h0000_0004, 0, 1'b1};
        tbl[2] = '{32'h0000_0008, 0, 1'b1};
        tbl[3] = '{32'h0000_000C, 0, 1'b1};
        tbl[4] = '{32'h0000_0400, 0, 1'b0};
        tbl[5] = '{32'h0000_0000, 5, 1'b0};
        tbl[6] = '{32'h0000_0404, 0, 1'b0};
        tbl[7] = '{32'h0000_0010, 1, 1'b0};
        tbl[8] = '{32'h0000_0408, 0, 1'b1};
        tbl[9] = '{32'h0000_0017, 0, 1'b1};

        // Reset with a pending fetch: outputs must stay quiet.
        rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr_o, c_nop);
        @(negedge clk); rst = 1'b0; fetch_req = 1'b0;

        for (int i = 0; i < 10; i++) begin
            fetch(tbl[i].addr, tbl[i].gap, -1, tbl[i].exp_hit);
        end

        do_flush();
        fetch(32'h0000_0010, 0, -1, 1'b0);
        fetch(32'h0000_0014, 1, 0, 1'b0);
        fetch(32'h0000_0018, 0, -1, 1'b1);
        fetch(32'h0000_0000, 2, 2, 1'b0);
        fetch(32'h0000_0000, 0, -1, 1'b0);
        fetch(32'h0000_0010, 0, -1, 1'b0);
        fetch(32'h0000_0020, 0, 4, 1'b0);
        fetch(32'h0000_0000, 0, -1, 1'b0);

        // Reset after two of four beats.
        @(negedge clk); fetch_addr = 32'h0000_2000; fetch_req = 1'b1; #1;
        chk1("rm_miss_stall", stall_o, 1'b1);
        @(negedge clk); #1;
        chk1("rm_req", mem_req, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); mem_rvalid = 1'b1; mem_rdata = mem_val(32'h2000 + 32'(4 * k));
        end
        @(negedge clk); mem_rvalid = 1'b0; rst = 1'b1; #1;
        chk1("rm_req_async", mem_req, 1'b0);
        chk1("rm_stall_async", stall_o, 1'b0);
        chk1("rm_valid", instr_valid, 1'b0);
        chk("rm_instr", instr_o, c_nop);
        @(negedge clk); rst = 1'b0; fetch_req = 1'b0;
        line_tab.delete();
        fetch(32'h0000_2000, 1, -1, 1'b0);
        fetch(32'h0000_2008, 0, -1, 1'b1);

        // Stray beats while no refill is outstanding.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); fetch_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom; #1;
            chk1("stray_req", mem_req, 1'b0);
        end
        @(negedge clk); mem_rvalid = 1'b0;
        fetch(32'h0000_200C, 0, -1, 1'b1);
        fetch(32'h0000_2004, 0, -1, 1'b1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          r;
            int          fl;
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                   | 32'($urandom_range(0, 15));
            fl = (r == 1) ? 0 : (r == 2) ? 1 + $urandom_range(0, 3) : -1;
            if (r == 0) do_flush();
            model_fetch(a, $urandom_range(0, 3), fl);
            if (r == 3) begin
                @(negedge clk); fetch_req = 1'b0; #1;
                chk1("idle_valid", instr_valid, 1'b0);
                chk1("idle_stall", stall_o, 1'b0);
            end
        end

        @(negedge clk); fetch_req = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
